// File: rtl/xv.sv
// Shared Xosera constants: bus strobe polarities used by the pad ring and the
// PLL settings used by the board top level.
package xv;

    // Bus chip-select asserted level and read/not-write "read" level.
    localparam logic CS_ENABLED = 1'b0;
    localparam logic RnW_READ   = 1'b1;

    // PLL settings for the board top level (12 MHz in, ~25.1 MHz pixel clock).
    localparam logic [3:0] PLL_DIVR = 4'd0;
    localparam logic [6:0] PLL_DIVF = 7'd66;
    localparam logic [2:0] PLL_DIVQ = 3'd5;

    // Flash image number handed to the warm-boot primitive.
    typedef logic [1:0] boot_image_t;

endpackage

// File: rtl/pad_tristate.sv
// Generic bidirectional pad group. The pins are driven with d_i while oe_i is
// high and float otherwise; d_o always shows the pin state. A vendor pad
// primitive can replace this module at synthesis.
module pad_tristate #(
    parameter int unsigned BUS_W = 8
) (
    input  logic             oe_i,
    input  logic [BUS_W-1:0] d_i,
    output logic [BUS_W-1:0] d_o,
    inout  wire  [BUS_W-1:0] pad_io
);

    assign pad_io = oe_i ? d_i : {BUS_W{1'bz}};
    assign d_o    = pad_io;

endmodule

// File: rtl/xosera_pad_ring.sv
// Board-side I/O ring for Xosera: bus pad direction control, registered video
// and interrupt outputs, DDR pixel clock for DV PMODs, PLL-lock core reset and
// sticky warm-boot request.
// Optional feature: define BUS_DTACK_EN to add the core_dtack_i/bus_dtack_o
// passthrough (the top level then uses the serial TX pin for DTACK).
module xosera_pad_ring
    import xv::*;
#(
    parameter int unsigned BUS_W   = 8,
    parameter int unsigned COLOR_W = 4
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic               pll_lock_i,
    output logic               core_reset_o,
    input  logic               bus_cs_n_i,
    input  logic               bus_rd_nwr_i,
    inout  wire  [BUS_W-1:0]   bus_data_io,
    output logic [BUS_W-1:0]   core_data_o,
    input  logic [BUS_W-1:0]   core_data_i,
    input  logic               core_intr_i,
    output logic               bus_intr_o,
`ifdef BUS_DTACK_EN
    input  logic               core_dtack_i,
    output logic               bus_dtack_o,
`endif
    input  logic [COLOR_W-1:0] core_red_i,
    input  logic [COLOR_W-1:0] core_green_i,
    input  logic [COLOR_W-1:0] core_blue_i,
    input  logic               core_hs_i,
    input  logic               core_vs_i,
    input  logic               core_de_i,
    output logic [COLOR_W-1:0] vga_red_o,
    output logic [COLOR_W-1:0] vga_green_o,
    output logic [COLOR_W-1:0] vga_blue_o,
    output logic               vga_hs_o,
    output logic               vga_vs_o,
    output logic               dv_de_o,
    output logic               dv_clk_o,
    input  logic               reconfig_i,
    input  logic [1:0]         boot_select_i,
    output logic               warmboot_o,
    output logic [1:0]         boot_image_o
);

    logic               out_ena;
    logic [BUS_W-1:0]   data_out_q;
    logic               intr_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               hs_q, vs_q, de_q;
    logic               core_reset_q;
    logic               dv_pos_q, dv_neg_q;
    logic               reconfig_q;
    boot_image_t        boot_sel_q;
    logic               warmboot_q, warmboot_d;
    boot_image_t        boot_image_q, boot_image_d;

    // Direction is decoded straight from the bus strobes so the pins turn
    // around in the same cycle the host changes them.
    assign out_ena = (bus_cs_n_i == CS_ENABLED) && (bus_rd_nwr_i == RnW_READ);

    pad_tristate #(
        .BUS_W (BUS_W)
    ) u_bus_pads (
        .oe_i   (out_ena),
        .d_i    (data_out_q),
        .d_o    (core_data_o),
        .pad_io (bus_data_io)
    );

`ifdef BUS_DTACK_EN
    assign bus_dtack_o = core_dtack_i;
`endif

    // Pad-side data, video and interrupt registers: one clk of delay.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_out_q <= '0;
            intr_q     <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
        end else begin
            data_out_q <= core_data_i;
            intr_q     <= core_intr_i;
            red_q      <= core_red_i;
            green_q    <= core_green_i;
            blue_q     <= core_blue_i;
            hs_q       <= core_hs_i;
            vs_q       <= core_vs_i;
            de_q       <= core_de_i;
        end
    end

    assign bus_intr_o  = intr_q;
    assign vga_red_o   = red_q;
    assign vga_green_o = green_q;
    assign vga_blue_o  = blue_q;
    assign vga_hs_o    = hs_q;
    assign vga_vs_o    = vs_q;
    assign dv_de_o     = de_q;

    // Core reset follows PLL lock; only the core is reset on lock loss.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            core_reset_q <= 1'b1;
        end else begin
            core_reset_q <= !pll_lock_i;
        end
    end

    assign core_reset_o = core_reset_q;

    // DDR pixel clock: the XOR of the pair is 0 after each rising edge and 1
    // after each falling edge, giving ~clk without a clock-gating cell.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dv_pos_q <= 1'b0;
        end else begin
            dv_pos_q <= dv_neg_q;
        end
    end

    // Falling-edge half of the DDR pixel clock pair.
    always_ff @(negedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dv_neg_q <= 1'b0;
        end else begin
            dv_neg_q <= !dv_pos_q;
        end
    end

    assign dv_clk_o = dv_pos_q ^ dv_neg_q;

    // Warm boot latches once on the first registered request and then holds.
    always_comb begin
        warmboot_d   = warmboot_q;
        boot_image_d = boot_image_q;
        if (reconfig_q && !warmboot_q) begin
            warmboot_d   = 1'b1;
            boot_image_d = boot_sel_q;
        end
    end

    // Warm-boot input and sticky state registers.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            reconfig_q   <= 1'b0;
            boot_sel_q   <= '0;
            warmboot_q   <= 1'b0;
            boot_image_q <= '0;
        end else begin
            reconfig_q   <= reconfig_i;
            boot_sel_q   <= boot_select_i;
            warmboot_q   <= warmboot_d;
            boot_image_q <= boot_image_d;
        end
    end

    assign warmboot_o   = warmboot_q;
    assign boot_image_o = boot_image_q;

endmodule

// File: tb/tb_xosera_pad_ring.sv
// Scoreboard bench for xosera_pad_ring: the driver logs each cycle's inputs,
// derives expected registered outputs from the input history and queues them;
// a monitor pops and compares after every rising edge.
module tb_xosera_pad_ring;

    typedef struct {
        logic       lock;
        logic       cs_n;
        logic       rd;
        logic [7:0] cdata;
        logic       intr;
        logic       dtack;
        logic [3:0] r, g, b;
        logic       hs, vs, de;
        logic       reconfig;
        logic [1:0] bsel;
        logic       tb_oe;
        logic [7:0] tb_val;
    } stim_t;

    typedef struct {
        logic [7:0] bus;
        logic [3:0] r, g, b;
        logic       hs, vs, de, intr, core_reset, wb;
        logic [1:0] img;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    stim_t      cur;
    logic       tb_oe;
    logic [7:0] tb_val;
    wire  [7:0] bus_data;
    logic [7:0] core_data_o;
    logic       core_reset, bus_intr, dv_clk, warmboot, dv_de, vga_hs, vga_vs;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [1:0] boot_image;
`ifdef BUS_DTACK_EN
    logic       bus_dtack;
`endif

    stim_t      hist[$];
    exp_t       sbq[$];
    logic [7:0] last_cd;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    assign bus_data = tb_oe ? tb_val : 8'bz;

    xosera_pad_ring #(
        .BUS_W   (8),
        .COLOR_W (4)
    ) dut (
        .clk           (clk),
        .reset_n_i     (reset_n),
        .pll_lock_i    (cur.lock),
        .core_reset_o  (core_reset),
        .bus_cs_n_i    (cur.cs_n),
        .bus_rd_nwr_i  (cur.rd),
        .bus_data_io   (bus_data),
        .core_data_o   (core_data_o),
        .core_data_i   (cur.cdata),
        .core_intr_i   (cur.intr),
        .bus_intr_o    (bus_intr),
`ifdef BUS_DTACK_EN
        .core_dtack_i  (cur.dtack),
        .bus_dtack_o   (bus_dtack),
`endif
        .core_red_i    (cur.r),
        .core_green_i  (cur.g),
        .core_blue_i   (cur.b),
        .core_hs_i     (cur.hs),
        .core_vs_i     (cur.vs),
        .core_de_i     (cur.de),
        .vga_red_o     (vga_r),
        .vga_green_o   (vga_g),
        .vga_blue_o    (vga_b),
        .vga_hs_o      (vga_hs),
        .vga_vs_o      (vga_vs),
        .dv_de_o       (dv_de),
        .dv_clk_o      (dv_clk),
        .reconfig_i    (cur.reconfig),
        .boot_select_i (cur.bsel),
        .warmboot_o    (warmboot),
        .boot_image_o  (boot_image)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{lock: 1'b1, cs_n: 1'b1, rd: 1'b1, cdata: 8'h00, intr: 1'b0, dtack: 1'b0,
              r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b0, vs: 1'b0, de: 1'b0,
              reconfig: 1'b0, bsel: 2'b00, tb_oe: 1'b0, tb_val: 8'h00};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s          = idle();
        s.lock     = ($urandom_range(0, 15) != 0);
        s.cs_n     = 1'($urandom_range(0, 1));
        s.rd       = 1'($urandom_range(0, 1));
        s.cdata    = 8'($urandom);
        s.intr     = 1'($urandom_range(0, 1));
        s.dtack    = 1'($urandom_range(0, 1));
        s.r        = 4'($urandom);
        s.g        = 4'($urandom);
        s.b        = 4'($urandom);
        s.hs       = 1'($urandom_range(0, 1));
        s.vs       = 1'($urandom_range(0, 1));
        s.de       = 1'($urandom_range(0, 1));
        s.reconfig = ($urandom_range(0, 39) == 0);
        s.bsel     = 2'($urandom);
        s.tb_oe    = !(!s.cs_n && s.rd) && ($urandom_range(0, 1) == 1);
        s.tb_val   = 8'($urandom);
        return s;
    endfunction

    // Async reset with the bus read-enabled: pads must drive zero.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cur     = idle();
        cur.cs_n = 1'b0;
        tb_oe   = 1'b0;
        #1;
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_warmboot", 32'(warmboot), 32'd0);
        chk("rst_boot_image", 32'(boot_image), 32'd0);
        chk("rst_vga", {vga_r, vga_g, vga_b, vga_hs, vga_vs, dv_de, bus_intr}, 32'd0);
        chk("rst_bus_drive0", 32'(bus_data), 32'h00);
        chk("rst_dv_clk_lo", 32'(dv_clk), 32'd0);
        cur.cs_n = 1'b1;
        #1;
        chk("rst_bus_z", 32'(bus_data), 32'(8'bz));
        @(posedge clk);
        #1;
        chk("rst_dv_clk_hold", 32'(dv_clk), 32'd0);
        chk("rst_core_reset_hold", 32'(core_reset), 32'd1);
        #1;
        reset_n = 1'b1;
        hist.delete();
        last_cd = 8'h00;
    endtask

    // Apply one cycle of stimulus at the falling edge and queue what the
    // outputs must be after the following rising edge.
    task automatic cycle(input stim_t s);
        exp_t       e;
        int         n;
        logic       rd_now;
        logic [7:0] exp_bus;
        @(negedge clk);
        cur    = s;
        tb_oe  = s.tb_oe;
        tb_val = s.tb_val;
        hist.push_back(s);
        n = hist.size() - 1;
        rd_now       = !s.cs_n && s.rd;
        e.bus        = rd_now ? s.cdata : (s.tb_oe ? s.tb_val : 8'bz);
        e.r          = s.r;
        e.g          = s.g;
        e.b          = s.b;
        e.hs         = s.hs;
        e.vs         = s.vs;
        e.de         = s.de;
        e.intr       = s.intr;
        e.core_reset = !s.lock;
        e.wb         = 1'b0;
        e.img        = 2'b00;
        // Warm boot fires one clk after the first registered request.
        for (int m = 0; m < n; m++) begin
            if (hist[m].reconfig) begin
                e.wb  = 1'b1;
                e.img = hist[m].bsel;
                break;
            end
        end
        sbq.push_back(e);
        #1;
        exp_bus = rd_now ? last_cd : (s.tb_oe ? s.tb_val : 8'bz);
        chk("comb_bus", 32'(bus_data), 32'(exp_bus));
        chk("comb_core_data", 32'(core_data_o), 32'(exp_bus));
        chk("dv_clk_hi", 32'(dv_clk), 32'd1);
`ifdef BUS_DTACK_EN
        chk("dtack", 32'(bus_dtack), 32'(s.dtack));
`endif
        last_cd = s.cdata;
    endtask

    // Monitor: compare registered outputs after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("bus", 32'(bus_data), 32'(e.bus));
                chk("core_data", 32'(core_data_o), 32'(e.bus));
                chk("rgb", {vga_r, vga_g, vga_b}, {e.r, e.g, e.b});
                chk("sync_de", {vga_hs, vga_vs, dv_de}, {e.hs, e.vs, e.de});
                chk("intr", 32'(bus_intr), 32'(e.intr));
                chk("core_reset", 32'(core_reset), 32'(e.core_reset));
                chk("warmboot", 32'(warmboot), 32'(e.wb));
                chk("boot_image", 32'(boot_image), 32'(e.img));
                chk("dv_clk_lo", 32'(dv_clk), 32'd0);
            end
        end
    end

    initial begin
        stim_t s;
        reset_n = 1'b0;
        cur     = idle();
        tb_oe   = 1'b0;
        tb_val  = 8'h00;
        last_cd = 8'h00;
        do_reset();

        // Bus read of A5, then deselect.
        s = idle(); s.cdata = 8'hA5; cycle(s);
        s.cs_n = 1'b0; s.rd = 1'b1; cycle(s);
        s.cs_n = 1'b1; cycle(s);
        // Read starting as core data changes shows the previous value.
        s = idle(); s.cdata = 8'h11; cycle(s);
        s.cdata = 8'h22; s.cs_n = 1'b0; s.rd = 1'b1; cycle(s);
        // Bus write: host drives 3C, then releases with ring not driving.
        s = idle(); s.cs_n = 1'b0; s.rd = 1'b0; s.tb_oe = 1'b1; s.tb_val = 8'h3C; cycle(s);
        s.tb_oe = 1'b0; cycle(s);
        // Video step.
        s = idle(); s.r = 4'h0; s.hs = 1'b1; cycle(s);
        s.r = 4'hF; s.hs = 1'b0; cycle(s);
        cycle(s);
        // Lock loss for three cycles.
        s = idle(); s.lock = 1'b0;
        repeat (3) cycle(s);
        s.lock = 1'b1;
        repeat (2) cycle(s);
        // Warm boot, then an ignored second request.
        s = idle(); s.bsel = 2'b10; s.reconfig = 1'b1; cycle(s);
        s.reconfig = 1'b0;
        repeat (3) cycle(s);
        s.bsel = 2'b01; s.reconfig = 1'b1; cycle(s);
        s.reconfig = 1'b0;
        repeat (3) cycle(s);

        // Random traffic across two reset epochs.
        for (int ep = 0; ep < 2; ep++) begin
            do_reset();
            for (int i = 0; i < 300; i++) cycle(rnd());
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
